// File: rtl/decode_stage_if.sv
// Fetch-to-execute decode channel: input handshake, flush, output bundle and counter.
// With SYSTEM_DECODE_EN defined, the bundle also carries out_ecall/out_ebreak.
interface decode_stage_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [XLEN-1:0]     in_pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [2:0]          out_funct3;
  logic                out_funct7b5;
  logic [XLEN-1:0]     out_imm;
  logic                out_reg_write;
  logic                out_alu_src;
  logic                out_mem_write;
  logic                out_mem_read;
  logic                out_mem_to_reg;
  logic                out_branch;
  logic                out_jump;
  logic                out_jalr;
  logic                out_lui;
  logic [ALU_OP_W-1:0] out_alu_op;
  logic                out_illegal;
  logic [CNT_W-1:0]    decode_count;
`ifdef SYSTEM_DECODE_EN
  logic                out_ecall;
  logic                out_ebreak;
`endif

  modport master (
`ifdef SYSTEM_DECODE_EN
    input  out_ecall, out_ebreak,
`endif
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3,
           out_funct7b5, out_imm, out_reg_write, out_alu_src, out_mem_write,
           out_mem_read, out_mem_to_reg, out_branch, out_jump, out_jalr, out_lui,
           out_alu_op, out_illegal, decode_count
  );

  modport slave (
`ifdef SYSTEM_DECODE_EN
    output out_ecall, out_ebreak,
`endif
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3,
           out_funct7b5, out_imm, out_reg_write, out_alu_src, out_mem_write,
           out_mem_read, out_mem_to_reg, out_branch, out_jump, out_jalr, out_lui,
           out_alu_op, out_illegal, decode_count
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32/RV64 decode stage with valid/ready backpressure, flush, illegal
// detection and handoff counter. Define SYSTEM_DECODE_EN to decode ecall/ebreak.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IALU   = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
`ifdef SYSTEM_DECODE_EN
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
`endif

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'b000);
  localparam logic [ALU_OP_W-1:0] ALU_BR  = ALU_OP_W'(3'b001);
  localparam logic [ALU_OP_W-1:0] ALU_R   = ALU_OP_W'(3'b010);
  localparam logic [ALU_OP_W-1:0] ALU_I   = ALU_OP_W'(3'b011);
  localparam logic [ALU_OP_W-1:0] ALU_U   = ALU_OP_W'(3'b101);

  typedef struct packed {
    logic                reg_write;
    logic                alu_src;
    logic                mem_write;
    logic                mem_read;
    logic                mem_to_reg;
    logic                branch;
    logic                jump;
    logic                jalr;
    logic                lui;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
`ifdef SYSTEM_DECODE_EN
    logic                ecall;
    logic                ebreak;
`endif
    logic [XLEN-1:0]     imm;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            funct7b5;
    ctrl_t           ctrl;
  } bundle_t;

  logic [31:0]      instr;
  logic [4:0]       opc;
  logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  ctrl_t            dec;
  bundle_t          nxt, held;
  logic             valid;
  logic             capture, handoff;
  logic [CNT_W-1:0] count;

  assign instr = bus.in_instr;
  assign opc   = instr[6:2];

  // Every immediate form keeps instr[31] as its sign bit, so build 32-bit forms first.
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec   = '0;
    imm32 = '0;
    if (instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (opc)
        OP_R: begin
          dec.reg_write = 1'b1;
          dec.alu_op    = ALU_R;
        end
        OP_IALU: begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = ALU_I;
          imm32         = imm_i;
        end
        OP_LOAD: begin
          dec.alu_src    = 1'b1;
          dec.reg_write  = 1'b1;
          dec.mem_read   = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.alu_op     = ALU_ADD;
          imm32          = imm_i;
        end
        OP_STORE: begin
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          dec.alu_op    = ALU_ADD;
          imm32         = imm_s;
        end
        OP_BRANCH: begin
          dec.branch = 1'b1;
          dec.alu_op = ALU_BR;
          imm32      = imm_b;
        end
        OP_JAL: begin
          dec.jump      = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.alu_op    = ALU_ADD;
          imm32         = imm_j;
        end
        OP_JALR: begin
          dec.jump      = 1'b1;
          dec.jalr      = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.alu_op    = ALU_ADD;
          imm32         = imm_i;
        end
        OP_LUI: begin
          dec.lui       = 1'b1;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = ALU_U;
          imm32         = imm_u;
        end
        OP_AUIPC: begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = ALU_U;
          imm32         = imm_u;
        end
`ifdef SYSTEM_DECODE_EN
        OP_SYSTEM: begin
          imm32 = imm_i;
          if (instr[14:12] == 3'b000 && instr[31:20] == 12'h000)
            dec.ecall = 1'b1;
          else if (instr[14:12] == 3'b000 && instr[31:20] == 12'h001)
            dec.ebreak = 1'b1;
          else
            dec.illegal = 1'b1;
        end
`endif
        default: dec.illegal = 1'b1;
      endcase
    end
    dec.imm = XLEN'($signed(imm32));
  end

  always_comb begin
    nxt          = '0;
    nxt.pc       = bus.in_pc;
    nxt.rd       = instr[11:7];
    nxt.rs1      = instr[19:15];
    nxt.rs2      = instr[24:20];
    nxt.funct3   = instr[14:12];
    nxt.funct7b5 = instr[30];
    nxt.ctrl     = dec;
  end

  // The held bundle only reloads on capture, and capture needs in_ready, so a
  // stalled bundle stays put without a separate hold path.
  assign bus.in_ready = !valid || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;
  assign handoff      = valid && bus.out_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      held  <= '0;
      count <= '0;
    end else begin
      if (bus.flush)
        valid <= 1'b0;
      else if (capture) begin
        valid <= 1'b1;
        held  <= nxt;
      end else if (bus.out_ready)
        valid <= 1'b0;
      if (handoff)
        count <= count + CNT_W'(1);
    end
  end

  assign bus.out_valid      = valid;
  assign bus.out_pc         = held.pc;
  assign bus.out_rd         = held.rd;
  assign bus.out_rs1        = held.rs1;
  assign bus.out_rs2        = held.rs2;
  assign bus.out_funct3     = held.funct3;
  assign bus.out_funct7b5   = held.funct7b5;
  assign bus.out_imm        = held.ctrl.imm;
  assign bus.out_reg_write  = held.ctrl.reg_write;
  assign bus.out_alu_src    = held.ctrl.alu_src;
  assign bus.out_mem_write  = held.ctrl.mem_write;
  assign bus.out_mem_read   = held.ctrl.mem_read;
  assign bus.out_mem_to_reg = held.ctrl.mem_to_reg;
  assign bus.out_branch     = held.ctrl.branch;
  assign bus.out_jump       = held.ctrl.jump;
  assign bus.out_jalr       = held.ctrl.jalr;
  assign bus.out_lui        = held.ctrl.lui;
  assign bus.out_alu_op     = held.ctrl.alu_op;
  assign bus.out_illegal    = held.ctrl.illegal;
  assign bus.decode_count   = count;
`ifdef SYSTEM_DECODE_EN
  assign bus.out_ecall      = held.ctrl.ecall;
  assign bus.out_ebreak     = held.ctrl.ebreak;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, hand sequences for stall/flush,
// then random traffic against a queue-based transaction model.
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  localparam logic [8:0] RW = 9'h100, AS = 9'h080, MW = 9'h040, MR = 9'h020, M2R = 9'h010;
  localparam logic [8:0] BR = 9'h008, JMP = 9'h004, JR = 9'h002, LU = 9'h001;
`ifdef SYSTEM_DECODE_EN
  localparam logic SYS_ILL = 1'b0;
`else
  localparam logic SYS_ILL = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(XLEN), .ALU_OP_W(3), .CNT_W(CNT_W)) bus ();
  decode_stage #(.XLEN(XLEN), .ALU_OP_W(3), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [8:0]  ctrl;
    logic [2:0]  alu_op;
    logic        illegal;
    logic        ecall;
    logic        ebreak;
    logic        imm_known;
    logic [63:0] imm;
  } exp_t;

  typedef struct {
    exp_t            e;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } txn_t;

  typedef struct {
    logic [31:0] instr;
    logic [8:0]  ctrl;
    logic [2:0]  alu_op;
    logic        ill;
    logic        imm_chk;
    logic [63:0] imm;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  txn_t q[$];
  int   cnt_m = 0;
  vec_t vt[12];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Decode straight from the ISA tables: full 7-bit opcodes, immediates by signed shifts.
  function automatic exp_t model(logic [31:0] ins);
    exp_t   e;
    longint si;
    si = longint'($signed(ins));
    e = '{ctrl: '0, alu_op: '0, illegal: 1'b0, ecall: 1'b0, ebreak: 1'b0, imm_known: 1'b1, imm: '0};
    case (ins[6:0])
      7'h33: begin e.ctrl = RW;                 e.alu_op = 3'b010; e.imm = 0; end
      7'h13: begin e.ctrl = RW | AS;            e.alu_op = 3'b011; e.imm = si >>> 20; end
      7'h03: begin e.ctrl = RW | AS | MR | M2R; e.alu_op = 3'b000; e.imm = si >>> 20; end
      7'h23: begin
        e.ctrl = AS | MW; e.alu_op = 3'b000;
        e.imm = ((si >>> 25) << 5) | longint'(ins[11:7]);
      end
      7'h63: begin
        e.ctrl = BR; e.alu_op = 3'b001;
        e.imm = ((si >>> 31) << 12) | (longint'(ins[7]) << 11) | (longint'(ins[30:25]) << 5)
              | (longint'(ins[11:8]) << 1);
      end
      7'h6F: begin
        e.ctrl = JMP | RW | AS; e.alu_op = 3'b000;
        e.imm = ((si >>> 31) << 20) | (longint'(ins[19:12]) << 12) | (longint'(ins[20]) << 11)
              | (longint'(ins[30:21]) << 1);
      end
      7'h67: begin e.ctrl = JMP | JR | RW | AS; e.alu_op = 3'b000; e.imm = si >>> 20; end
      7'h37: begin e.ctrl = LU | AS | RW;       e.alu_op = 3'b101; e.imm = (si >>> 12) << 12; end
      7'h17: begin e.ctrl = AS | RW;            e.alu_op = 3'b101; e.imm = (si >>> 12) << 12; end
`ifdef SYSTEM_DECODE_EN
      7'h73: begin
        e.imm_known = 1'b0;
        if (ins == 32'h0000_0073)      e.ecall = 1'b1;
        else if (ins == 32'h0010_0073) e.ebreak = 1'b1;
        else                           e.illegal = 1'b1;
      end
`endif
      default: begin e.illegal = 1'b1; e.imm_known = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic check_bundle(txn_t t);
    chk("pc", bus.out_pc, t.pc);
    chk("fields", {bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3, bus.out_funct7b5},
        {t.instr[11:7], t.instr[19:15], t.instr[24:20], t.instr[14:12], t.instr[30]});
    chk("ctrl", {bus.out_reg_write, bus.out_alu_src, bus.out_mem_write, bus.out_mem_read,
                 bus.out_mem_to_reg, bus.out_branch, bus.out_jump, bus.out_jalr, bus.out_lui},
        t.e.ctrl);
    chk("alu_op", bus.out_alu_op, t.e.alu_op);
    chk("illegal", bus.out_illegal, t.e.illegal);
`ifdef SYSTEM_DECODE_EN
    chk("ecall", bus.out_ecall, t.e.ecall);
    chk("ebreak", bus.out_ebreak, t.e.ebreak);
`endif
    if (t.e.imm_known) chk("imm", bus.out_imm, t.e.imm[XLEN-1:0]);
  endtask

  // One clock: check in_ready, advance the model with the driven inputs, check outputs.
  task automatic cycle();
    logic rdy;
    txn_t t;
    rdy = (q.size() == 0) || bus.out_ready;
    #1;
    if (!rst) chk("in_ready", bus.in_ready, rdy);
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt_m = 0;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && bus.out_ready) begin
        void'(q.pop_front());
        cnt_m++;
      end
      if (bus.in_valid && rdy) begin
        t.e = model(bus.in_instr);
        t.instr = bus.in_instr;
        t.pc = bus.in_pc;
        q.push_back(t);
      end
    end
    #1;
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("count", bus.decode_count, cnt_m % (1 << CNT_W));
    if (q.size() != 0) check_bundle(q[0]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0B, 7'h00};
    r = $urandom();
    case ($urandom_range(0, 15))
      12: return 32'h0000_0073;
      13: return 32'h0010_0073;
      14, 15: return r;
      default: return {r[31:7], ops[$urandom_range(0, 11)]};
    endcase
  endfunction

  initial begin
    int c0;
    logic [XLEN-1:0] pc_b;

    vt[0]  = '{32'h0050_0093, RW | AS,            3'b011, 1'b0, 1'b1, 64'd5};
    vt[1]  = '{32'hFE01_0EE3, BR,                 3'b001, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
    vt[2]  = '{32'h0000_0000, 9'h000,             3'b000, 1'b1, 1'b0, 64'd0};
    vt[3]  = '{32'h0000_007F, 9'h000,             3'b000, 1'b1, 1'b0, 64'd0};
    vt[4]  = '{32'h0080_A103, RW | AS | MR | M2R, 3'b000, 1'b0, 1'b1, 64'd8};
    vt[5]  = '{32'hFE20_AE23, AS | MW,            3'b000, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
    vt[6]  = '{32'h0020_81B3, RW,                 3'b010, 1'b0, 1'b1, 64'd0};
    vt[7]  = '{32'h1234_52B7, LU | AS | RW,       3'b101, 1'b0, 1'b1, 64'h1234_5000};
    vt[8]  = '{32'h8000_0297, AS | RW,            3'b101, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000};
    vt[9]  = '{32'hFF9F_F0EF, JMP | RW | AS,      3'b000, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8};
    vt[10] = '{32'h0000_8067, JMP | JR | RW | AS, 3'b000, 1'b0, 1'b1, 64'd0};
    vt[11] = '{32'h0000_0073, 9'h000,             3'b000, SYS_ILL, 1'b0, 64'd0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    cycle();
    cycle();

    // Reset state: everything visible is zero, in_ready high with out_ready low.
    chk("rst_imm", bus.out_imm, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_misc", {bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct3, bus.out_funct7b5,
                     bus.out_reg_write, bus.out_alu_src, bus.out_mem_write, bus.out_mem_read,
                     bus.out_mem_to_reg, bus.out_branch, bus.out_jump, bus.out_jalr, bus.out_lui,
                     bus.out_alu_op, bus.out_illegal}, 0);
    rst = 1'b0;
    #1 chk("rst_in_ready", bus.in_ready, 1'b1);

    // Directed table: back-to-back captures with execute always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = vt[i].instr;
      bus.in_pc = XLEN'(32'h1000 + 4 * i);
      cycle();
      chk("tv_valid", bus.out_valid, 1'b1);
      chk("tv_ctrl", {bus.out_reg_write, bus.out_alu_src, bus.out_mem_write, bus.out_mem_read,
                      bus.out_mem_to_reg, bus.out_branch, bus.out_jump, bus.out_jalr, bus.out_lui},
          vt[i].ctrl);
      chk("tv_alu_op", bus.out_alu_op, vt[i].alu_op);
      chk("tv_illegal", bus.out_illegal, vt[i].ill);
      if (vt[i].imm_chk) chk("tv_imm", bus.out_imm, vt[i].imm[XLEN-1:0]);
    end
`ifdef SYSTEM_DECODE_EN
    chk("tv_ecall", bus.out_ecall, 1'b1);
    bus.in_instr = 32'h0010_0073;
    cycle();
    chk("tv_ebreak", bus.out_ebreak, 1'b1);
`else
    bus.in_instr = 32'h0010_0073;
    cycle();
    chk("tv_ebreak_ill", bus.out_illegal, 1'b1);
`endif
    bus.in_valid = 1'b0;
    cycle();

    // Stall three cycles with a new instruction waiting, then release with no bubble.
    bus.in_valid = 1'b1; bus.in_instr = 32'h0050_0093; bus.in_pc = XLEN'(32'h2000);
    cycle();
    bus.out_ready = 1'b0;
    bus.in_instr = 32'hFE01_0EE3; pc_b = XLEN'(32'h2004); bus.in_pc = pc_b;
    c0 = cnt_m;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", bus.out_pc, 32'h2000);
    end
    chk("stall_cnt", bus.decode_count, c0 % (1 << CNT_W));
    bus.out_ready = 1'b1;
    cycle();
    chk("release_pc", bus.out_pc, pc_b);
    chk("release_valid", bus.out_valid, 1'b1);

    // Flush while holding a stalled bundle with a new instruction offered.
    bus.out_ready = 1'b0; bus.in_instr = 32'h0080_A103; bus.in_pc = XLEN'(32'h3000);
    cycle();
    c0 = cnt_m;
    bus.flush = 1'b1;
    cycle();
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_cnt", bus.decode_count, c0 % (1 << CNT_W));
    // Flush also suppresses a handoff that would otherwise count.
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    cycle();
    c0 = cnt_m;
    bus.flush = 1'b1;
    cycle();
    chk("flush_ho_cnt", bus.decode_count, c0 % (1 << CNT_W));
    bus.flush = 1'b0;

    // Random traffic; CNT_W is small so the counter wraps many times.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.in_instr = rand_instr();
      bus.in_pc = XLEN'({$urandom(), $urandom()});
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
